// File: rtl/turbosound_mixer_n.sv
// Time-multiplexed N-chip PSG+FM stereo mixer with one final saturation.
// Optional saturation-event counter: define TSMIX_OVF_COUNT_EN.
module turbosound_mixer_n #(
    parameter int NUM_CHIPS = 2,
    parameter int PSG_W     = 8,
    parameter int FM_W      = 16,
    parameter int OUT_W     = 12
) (
    input  logic                      CLK,
    input  logic                      RESET_s,
    input  logic                      CE_SAMPLE,
    input  logic                      CFG_WR,
    input  logic [7:0]                CFG_DI,
    input  logic                      FM_ENA,
    input  logic [NUM_CHIPS*PSG_W-1:0] PSG_A,
    input  logic [NUM_CHIPS*PSG_W-1:0] PSG_B,
    input  logic [NUM_CHIPS*PSG_W-1:0] PSG_C,
    input  logic [NUM_CHIPS*FM_W-1:0]  FM,
    output logic [OUT_W-1:0]          CHANNEL_L,
    output logic [OUT_W-1:0]          CHANNEL_R,
    output logic                      VALID,
    output logic                      BUSY,
    output logic [15:0]               OVF_CNT
);

    localparam int ACC_W  = OUT_W + 4;
    localparam int IDX_W  = (NUM_CHIPS > 1) ? $clog2(NUM_CHIPS) : 1;
    localparam int FM_SH0 = FM_W - OUT_W + 2;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CHIPS - 1);
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

    typedef enum logic [1:0] {IDLE, ACCUM, SAT} state_t;

    state_t state, state_nx;

    logic [7:0]                 cfg;
    logic [7:0]                 cfg_q;
    logic                       fm_ena_q;
    logic [NUM_CHIPS*PSG_W-1:0] psg_a_q;
    logic [NUM_CHIPS*PSG_W-1:0] psg_b_q;
    logic [NUM_CHIPS*PSG_W-1:0] psg_c_q;
    logic [NUM_CHIPS*FM_W-1:0]  fm_q;
    logic [IDX_W-1:0]           idx;
    logic signed [ACC_W-1:0]    acc_l;
    logic signed [ACC_W-1:0]    acc_r;

    logic                       start;
    logic [PSG_W-1:0]           ch_a, ch_b, ch_c;
    logic signed [FM_W-1:0]     ch_fm;
    logic signed [FM_W-1:0]     fm_sh;
    logic                       ch_en;
    logic signed [ACC_W-1:0]    ea, eb, ec, fm_x;
    logic signed [ACC_W-1:0]    add_l, add_r;
    logic [OUT_W-1:0]           sat_l, sat_r;

    // The VALID cycle is the SAT->IDLE handoff; a strobe there is dropped.
    assign start = (state == IDLE) && CE_SAMPLE && !VALID;

    function automatic logic [OUT_W-1:0] clamp(input logic signed [ACC_W-1:0] v);
        if (v > SAT_HI)
            return SAT_HI[OUT_W-1:0];
        else if (v < SAT_LO)
            return SAT_LO[OUT_W-1:0];
        else
            return v[OUT_W-1:0];
    endfunction

    always_ff @(posedge CLK or posedge RESET_s) begin
        if (RESET_s)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = ACCUM;
            ACCUM:   if (idx == LAST) state_nx = SAT;
            SAT:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        ch_a  = '0;
        ch_b  = '0;
        ch_c  = '0;
        ch_fm = '0;
        ch_en = 1'b0;
        for (int i = 0; i < NUM_CHIPS; i++) begin
            if (idx == IDX_W'(i)) begin
                ch_a  = psg_a_q[i*PSG_W +: PSG_W];
                ch_b  = psg_b_q[i*PSG_W +: PSG_W];
                ch_c  = psg_c_q[i*PSG_W +: PSG_W];
                ch_fm = fm_q[i*FM_W +: FM_W];
                ch_en = cfg_q[4+i];
            end
        end
    end

    always_comb begin
        ea    = ACC_W'(ch_a);
        eb    = ACC_W'(ch_b);
        ec    = ACC_W'(ch_c);
        fm_sh = ch_fm >>> (FM_SH0 + int'(cfg_q[3:2]));
        fm_x  = fm_ena_q ? ACC_W'(fm_sh) : '0;
        case (cfg_q[1:0])
            2'b01: begin
                add_l = (ea <<< 1) + ec + fm_x;
                add_r = (eb <<< 1) + ec + fm_x;
            end
            2'b10: begin
                add_l = ea + eb + ec + fm_x;
                add_r = ea + eb + ec + fm_x;
            end
            default: begin
                add_l = (ea <<< 1) + eb + fm_x;
                add_r = (ec <<< 1) + eb + fm_x;
            end
        endcase
    end

    assign sat_l = clamp(acc_l);
    assign sat_r = clamp(acc_r);

    always_ff @(posedge CLK or posedge RESET_s) begin
        if (RESET_s) begin
            cfg       <= 8'hF0;
            cfg_q     <= 8'hF0;
            fm_ena_q  <= 1'b0;
            psg_a_q   <= '0;
            psg_b_q   <= '0;
            psg_c_q   <= '0;
            fm_q      <= '0;
            idx       <= '0;
            acc_l     <= '0;
            acc_r     <= '0;
            CHANNEL_L <= '0;
            CHANNEL_R <= '0;
            VALID     <= 1'b0;
            BUSY      <= 1'b0;
        end else begin
            VALID <= 1'b0;
            if (CFG_WR)
                cfg <= CFG_DI;
            case (state)
                IDLE: begin
                    if (start) begin
                        cfg_q    <= cfg;
                        fm_ena_q <= FM_ENA;
                        psg_a_q  <= PSG_A;
                        psg_b_q  <= PSG_B;
                        psg_c_q  <= PSG_C;
                        fm_q     <= FM;
                        idx      <= '0;
                        acc_l    <= '0;
                        acc_r    <= '0;
                        BUSY     <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (ch_en) begin
                        acc_l <= acc_l + add_l;
                        acc_r <= acc_r + add_r;
                    end
                    idx <= idx + 1'b1;
                end
                SAT: begin
                    CHANNEL_L <= sat_l;
                    CHANNEL_R <= sat_r;
                    VALID     <= 1'b1;
                    BUSY      <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef TSMIX_OVF_COUNT_EN
    logic clip;

    assign clip = (ACC_W'($signed(sat_l)) != acc_l) ||
                  (ACC_W'($signed(sat_r)) != acc_r);

    always_ff @(posedge CLK or posedge RESET_s) begin
        if (RESET_s)
            OVF_CNT <= '0;
        else if (CFG_WR && CFG_DI == 8'h00)
            OVF_CNT <= '0;
        else if (state == SAT && clip && OVF_CNT != 16'hFFFF)
            OVF_CNT <= OVF_CNT + 16'd1;
    end
`else
    assign OVF_CNT = '0;
`endif

endmodule

// File: tb/tb_turbosound_mixer_n.sv
// Self-checking bench for turbosound_mixer_n (NUM_CHIPS=2 build).
// Expected mixes come from an integer model of the mixing rules.
module tb_turbosound_mixer_n;

    localparam int N     = 2;
    localparam int PW    = 8;
    localparam int FW    = 16;
    localparam int OW    = 12;
    localparam int HI    = 2 ** (OW - 1) - 1;
    localparam int LO    = -(2 ** (OW - 1));
    localparam int SH0   = FW - OW + 2;
    localparam int LAT   = N + 1;

    logic            CLK = 1'b0;
    logic            RESET_s = 1'b1;
    logic            CE_SAMPLE = 1'b0;
    logic            CFG_WR = 1'b0;
    logic [7:0]      CFG_DI = '0;
    logic            FM_ENA = 1'b0;
    logic [N*PW-1:0] PSG_A = '0;
    logic [N*PW-1:0] PSG_B = '0;
    logic [N*PW-1:0] PSG_C = '0;
    logic [N*FW-1:0] FM = '0;
    logic [OW-1:0]   CHANNEL_L;
    logic [OW-1:0]   CHANNEL_R;
    logic            VALID;
    logic            BUSY;
    logic [15:0]     OVF_CNT;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] m_cfg = 8'hF0;
    int exp_ovf = 0;

    turbosound_mixer_n #(.NUM_CHIPS(N), .PSG_W(PW), .FM_W(FW), .OUT_W(OW)) dut (
        .CLK(CLK), .RESET_s(RESET_s), .CE_SAMPLE(CE_SAMPLE),
        .CFG_WR(CFG_WR), .CFG_DI(CFG_DI), .FM_ENA(FM_ENA),
        .PSG_A(PSG_A), .PSG_B(PSG_B), .PSG_C(PSG_C), .FM(FM),
        .CHANNEL_L(CHANNEL_L), .CHANNEL_R(CHANNEL_R),
        .VALID(VALID), .BUSY(BUSY), .OVF_CNT(OVF_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic void model(input logic [7:0] cf, input bit fe,
                                  output int l, output int r,
                                  output bit clipped);
        int a, b, c, f;
        l = 0;
        r = 0;
        for (int i = 0; i < N; i++) begin
            if (cf[4+i]) begin
                a = int'(PSG_A[i*PW +: PW]);
                b = int'(PSG_B[i*PW +: PW]);
                c = int'(PSG_C[i*PW +: PW]);
                case (cf[1:0])
                    2'b01:   begin l += 2*a + c; r += 2*b + c; end
                    2'b10:   begin l += a + b + c; r += a + b + c; end
                    default: begin l += 2*a + b; r += 2*c + b; end
                endcase
                if (fe) begin
                    f = int'($signed(FM[i*FW +: FW])) >>> (SH0 + int'(cf[3:2]));
                    l += f;
                    r += f;
                end
            end
        end
        clipped = (l > HI) || (l < LO) || (r > HI) || (r < LO);
        if (l > HI) l = HI;
        if (l < LO) l = LO;
        if (r > HI) r = HI;
        if (r < LO) r = LO;
    endfunction

    function automatic void note_ovf(input bit clipped);
`ifdef TSMIX_OVF_COUNT_EN
        if (clipped && exp_ovf < 65535) exp_ovf++;
`endif
    endfunction

    task automatic write_cfg(input logic [7:0] v);
        CFG_WR = 1'b1;
        CFG_DI = v;
        tick();
        CFG_WR = 1'b0;
        m_cfg = v;
        if (v == 8'h00) exp_ovf = 0;
    endtask

    // lat counts edges after the sampling edge until VALID (N+1 edges).
    task automatic run_sample(output int l, output int r, output int lat,
                              output bit hs_ok);
        hs_ok = 1'b1;
        CE_SAMPLE = 1'b1;
        tick();
        CE_SAMPLE = 1'b0;
        lat = 0;
        while (!VALID && lat < 20) begin
            hs_ok &= BUSY;
            tick();
            lat++;
        end
        if (!VALID) lat = -1;
        hs_ok &= !BUSY;
        l = int'($signed(CHANNEL_L));
        r = int'($signed(CHANNEL_R));
        tick();
        hs_ok &= !VALID;
    endtask

    task automatic set_plan_psg();
        PSG_A = '0; PSG_B = '0; PSG_C = '0; FM = '0;
        PSG_A[7:0] = 8'h80;
        PSG_B[7:0] = 8'h40;
        PSG_C[7:0] = 8'h20;
        FM_ENA = 1'b0;
    endtask

    task automatic test_reset();
        vectors++;
        if (CHANNEL_L !== '0 || CHANNEL_R !== '0 || VALID !== 1'b0 ||
            BUSY !== 1'b0 || OVF_CNT !== 16'd0) begin
            miscompares++;
            $display("FAIL reset: L=%0h R=%0h V=%0b B=%0b O=%0h want all 0",
                     CHANNEL_L, CHANNEL_R, VALID, BUSY, OVF_CNT);
        end
    endtask

    task automatic test_psg_modes();
        logic [7:0] cfgs [4] = '{8'hF0, 8'hF1, 8'hF2, 8'hF3};
        int el [4] = '{320, 288, 224, 320};
        int er [4] = '{128, 160, 224, 128};
        int l, r, lat;
        bit ok;
        set_plan_psg();
        for (int k = 0; k < 4; k++) begin
            if (k > 0) write_cfg(cfgs[k]);
            run_sample(l, r, lat, ok);
            vectors++;
            if (l != el[k] || r != er[k]) begin
                miscompares++;
                $display("FAIL psg_mode%0d: L=%0d R=%0d want L=%0d R=%0d",
                         k, l, r, el[k], er[k]);
            end
            vectors++;
            if (lat != LAT || !ok) begin
                miscompares++;
                $display("FAIL psg_timing%0d: lat=%0d hs=%0b want lat=%0d hs=1",
                         k, lat, ok, LAT);
            end
        end
    endtask

    task automatic test_fm();
        logic [7:0]  cfgs [4] = '{8'hF0, 8'hF0, 8'h10, 8'hF4};
        logic [15:0] fm1  [4] = '{16'h0000, 16'h8000, 16'h8000, 16'h8000};
        int ex [4] = '{-512, -1024, -512, -512};
        int l, r, lat;
        bit ok;
        PSG_A = '0; PSG_B = '0; PSG_C = '0;
        FM_ENA = 1'b1;
        for (int k = 0; k < 4; k++) begin
            write_cfg(cfgs[k]);
            FM = {fm1[k], 16'h8000};
            run_sample(l, r, lat, ok);
            vectors++;
            if (l != ex[k] || r != ex[k] || lat != LAT || !ok) begin
                miscompares++;
                $display("FAIL fm%0d: L=%0d R=%0d lat=%0d want %0d lat=%0d",
                         k, l, r, lat, ex[k], LAT);
            end
        end
    endtask

    task automatic test_ovf();
        int l, r, lat, el, er;
        bit ok, clp;
        PSG_A = '1; PSG_B = '1; PSG_C = '1;
        FM = {16'h7FFF, 16'h7FFF};
        FM_ENA = 1'b1;
        write_cfg(8'hF2);
        model(m_cfg, FM_ENA, el, er, clp);
        note_ovf(clp);
        run_sample(l, r, lat, ok);
        vectors++;
        if (l != HI || r != HI || el != HI) begin
            miscompares++;
            $display("FAIL ovf_clamp: L=%0d R=%0d want %0d", l, r, HI);
        end
        vectors++;
        if (OVF_CNT !== 16'(exp_ovf)) begin
            miscompares++;
            $display("FAIL ovf_count: got %0d want %0d", OVF_CNT, exp_ovf);
        end
        write_cfg(8'h00);
        vectors++;
        if (OVF_CNT !== 16'(exp_ovf)) begin
            miscompares++;
            $display("FAIL ovf_clear: got %0d want %0d", OVF_CNT, exp_ovf);
        end
    endtask

    task automatic test_random();
        int l, r, lat, el, er;
        bit ok, clp;
        for (int k = 0; k < 30; k++) begin
            write_cfg(8'($urandom));
            for (int i = 0; i < N; i++) begin
                PSG_A[i*PW +: PW] = PW'($urandom);
                PSG_B[i*PW +: PW] = PW'($urandom);
                PSG_C[i*PW +: PW] = PW'($urandom);
                FM[i*FW +: FW] = FW'($urandom);
            end
            FM_ENA = 1'($urandom);
            model(m_cfg, FM_ENA, el, er, clp);
            note_ovf(clp);
            run_sample(l, r, lat, ok);
            vectors++;
            if (l != el || r != er || lat != LAT || !ok) begin
                miscompares++;
                $display("FAIL rand%0d cfg=%0h: L=%0d R=%0d lat=%0d hs=%0b want L=%0d R=%0d lat=%0d",
                         k, m_cfg, l, r, lat, ok, el, er, LAT);
            end
            vectors++;
            if (OVF_CNT !== 16'(exp_ovf)) begin
                miscompares++;
                $display("FAIL rand_ovf%0d: got %0d want %0d", k, OVF_CNT, exp_ovf);
            end
        end
    endtask

    task automatic test_back_to_back();
        int extra;
        set_plan_psg();
        write_cfg(8'hF0);
        CE_SAMPLE = 1'b1;
        tick();
        tick();
        CE_SAMPLE = 1'b0;
        CFG_WR = 1'b1;
        CFG_DI = 8'hF1;
        tick();
        CFG_WR = 1'b0;
        m_cfg = 8'hF1;
        tick();
        vectors++;
        if (VALID !== 1'b1 || int'($signed(CHANNEL_L)) != 320 ||
            int'($signed(CHANNEL_R)) != 128) begin
            miscompares++;
            $display("FAIL b2b_sample: V=%0b L=%0d R=%0d want V=1 L=320 R=128",
                     VALID, $signed(CHANNEL_L), $signed(CHANNEL_R));
        end
        CE_SAMPLE = 1'b1;
        tick();
        CE_SAMPLE = 1'b0;
        extra = 0;
        for (int k = 0; k < 10; k++) begin
            if (VALID) extra++;
            tick();
        end
        vectors++;
        if (extra != 0) begin
            miscompares++;
            $display("FAIL b2b_extra_valid: got %0d want 0", extra);
        end
    endtask

    task automatic test_mid_reset();
        int l, r, lat, seen;
        bit ok;
        set_plan_psg();
        write_cfg(8'hF2);
        CE_SAMPLE = 1'b1;
        tick();
        CE_SAMPLE = 1'b0;
        tick();
        RESET_s = 1'b1;
        #1;
        m_cfg = 8'hF0;
        exp_ovf = 0;
        vectors++;
        if (CHANNEL_L !== '0 || CHANNEL_R !== '0 || BUSY !== 1'b0 ||
            VALID !== 1'b0 || OVF_CNT !== 16'd0) begin
            miscompares++;
            $display("FAIL midreset_clear: L=%0d R=%0d B=%0b V=%0b O=%0d want 0",
                     CHANNEL_L, CHANNEL_R, BUSY, VALID, OVF_CNT);
        end
        tick();
        RESET_s = 1'b0;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            if (VALID || BUSY) seen++;
            tick();
        end
        vectors++;
        if (seen != 0) begin
            miscompares++;
            $display("FAIL midreset_novalid: got %0d active cycles want 0", seen);
        end
        run_sample(l, r, lat, ok);
        vectors++;
        if (l != 320 || r != 128 || lat != LAT || !ok) begin
            miscompares++;
            $display("FAIL midreset_resume: L=%0d R=%0d lat=%0d want L=320 R=128 lat=%0d",
                     l, r, lat, LAT);
        end
    endtask

    initial begin
        tick();
        tick();
        test_reset();
        RESET_s = 1'b0;
        tick();
        test_reset();
        test_psg_modes();
        test_fm();
        test_ovf();
        test_random();
        test_back_to_back();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
